mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_rr.sv | 30 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Types and constants shared by the memory arbiter, its round-robin
// selector and anything that talks to them.
//   state_e         : arbiter FSM states (IDLE, ACCESS, RESP)
//   req_id_e        : requester identity (REQ_CPU, REQ_DMA)
//   DEFAULT_TIMEOUT : default number of ACCESS cycles before an abort
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports and the memory port of the arbiter.
//   cpu_* / dma_*   : requester side (req/wr/addr/wdata in, done/err out)
//   rdata           : read data returned to the current owner
//   mem_*           : memory side strobes, address, data and ready
//   busy            : arbiter is in ACCESS or RESP
// Modports:
//   slave  : the arbiter's view
//   master : the view of whatever drives requests and models the memory
// ---------------------------------------------------------------------------
interface mem_arbiter_if;

    logic        cpu_req;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_done;
    logic        cpu_err;

    logic        dma_req;
    logic        dma_wr;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_done;
    logic        dma_err;

    logic [31:0] rdata;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_wr, dma_addr, dma_wdata,
        input  mem_rdata, mem_ready,
        output cpu_done, cpu_err, dma_done, dma_err,
        output rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_wr, dma_addr, dma_wdata,
        output mem_rdata, mem_ready,
        input  cpu_done, cpu_err, dma_done, dma_err,
        input  rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin winner select, purely combinational.
//   cpu_req, dma_req : current requests
//   last_grant       : requester granted most recently
//   grant_valid      : at least one request is pending
//   winner           : requester to grant (only meaningful with grant_valid)
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  req_id_e last_grant,
    output logic    grant_valid,
    output req_id_e winner
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant_valid = cpu_req | dma_req;
        winner      = REQ_CPU;
        if (cpu_req && dma_req) begin
            winner = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (dma_req) begin
            winner = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between a CPU and a DMA requester with
// round-robin arbitration and a per-access timeout.
//   TIMEOUT : ACCESS cycles allowed before the access ends with an error
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : requester and memory signals (mem_arbiter_if.slave)
// A transaction is IDLE (grant) -> ACCESS (strobe until ready or timeout)
// -> RESP (one-cycle done/err to the owner) -> IDLE.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    state_e      state;
    req_id_e     owner;
    req_id_e     last_grant;
    logic        wr_q;
    logic [7:0]  wait_cnt;

    logic        grant_valid;
    req_id_e     winner;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    rr_arb2 u_rr (
        .cpu_req     (bus.cpu_req),
        .dma_req     (bus.dma_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // Pick the winner's command so it can be latched on the grant edge.
    always_comb begin
        sel_wr    = bus.cpu_wr;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (winner == REQ_DMA) begin
            sel_wr    = bus.dma_wr;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

    // Arbiter FSM with all outputs registered. Done/err default low every
    // cycle and are only set on the ACCESS->RESP edge, so they last exactly
    // the RESP cycle. Ready is checked before the timeout so a ready
    // arriving in the final allowed cycle still completes normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= REQ_CPU;
            last_grant     <= REQ_DMA;
            wr_q           <= 1'b0;
            wait_cnt       <= 8'd0;
            bus.cpu_done   <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.dma_done   <= 1'b0;
            bus.dma_err    <= 1'b0;
            bus.rdata      <= 32'd0;
            bus.mem_rd     <= 1'b0;
            bus.mem_wr     <= 1'b0;
            bus.mem_addr   <= 32'd0;
            bus.mem_wdata  <= 32'd0;
            bus.busy       <= 1'b0;
        end else begin
            bus.cpu_done <= 1'b0;
            bus.cpu_err  <= 1'b0;
            bus.dma_done <= 1'b0;
            bus.dma_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= winner;
                        last_grant    <= winner;
                        wr_q          <= sel_wr;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_rd    <= !sel_wr;
                        bus.mem_wr    <= sel_wr;
                        bus.busy      <= 1'b1;
                        wait_cnt      <= 8'd0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!wr_q) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                        if (owner == REQ_CPU) begin
                            bus.cpu_done <= 1'b1;
                        end else begin
                            bus.dma_done <= 1'b1;
                        end
                        bus.mem_rd <= 1'b0;
                        bus.mem_wr <= 1'b0;
                        state      <= RESP;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        if (!wr_q) begin
                            bus.rdata <= 32'd0;
                        end
                        if (owner == REQ_CPU) begin
                            bus.cpu_err <= 1'b1;
                        end else begin
                            bus.dma_err <= 1'b1;
                        end
                        bus.mem_rd <= 1'b0;
                        bus.mem_wr <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single transactions with
// hand-computed results, then hand-written sequences for reset during an
// access and for back-to-back competing requests.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        cpu_req;
        logic        dma_req;
        logic        cpu_wr;
        logic        dma_wr;
        logic [31:0] cpu_addr;
        logic [31:0] dma_addr;
        logic [31:0] cpu_wdata;
        logic [31:0] dma_wdata;
        int          ready_delay;
        logic [31:0] mem_rdata;
        logic        exp_dma;
        logic        exp_err;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_strobes;
        int          exp_cycles;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   pass_cnt;
    vec_t vecs [9];

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 time-unit clock; inputs change and outputs are sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Runs one transaction from the table and checks everything about it.
    // ready_delay < 0 means the memory never answers.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int          cycles;
        int          strobes;
        int          both;
        logic        got_pulse;
        logic        last_rd;
        logic [31:0] addr_seen;
        logic [31:0] wdata_seen;
        logic [3:0]  pulses;
        logic [3:0]  exp_pulses;
        logic [1:0]  resp_strobes;
        logic [31:0] rdata_seen;
        cycles     = 0;
        strobes    = 0;
        both       = 0;
        got_pulse  = 1'b0;
        last_rd    = 1'b0;
        addr_seen  = 32'd0;
        wdata_seen = 32'd0;
        pulses     = 4'd0;
        resp_strobes = 2'd0;
        rdata_seen = 32'd0;

        @(negedge clk);
        bus.cpu_req   = v.cpu_req;
        bus.dma_req   = v.dma_req;
        bus.cpu_wr    = v.cpu_wr;
        bus.dma_wr    = v.dma_wr;
        bus.cpu_addr  = v.cpu_addr;
        bus.dma_addr  = v.dma_addr;
        bus.cpu_wdata = v.cpu_wdata;
        bus.dma_wdata = v.dma_wdata;
        bus.mem_rdata = v.mem_rdata;
        bus.mem_ready = 1'b0;
        @(posedge clk);

        while (!got_pulse && cycles < 40) begin
            @(negedge clk);
            cycles++;
            pulses = {bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err};
            if (pulses != 4'd0) begin
                got_pulse    = 1'b1;
                resp_strobes = {bus.mem_rd, bus.mem_wr};
                rdata_seen   = bus.rdata;
            end else begin
                if (bus.mem_rd && bus.mem_wr) both++;
                if (bus.mem_rd || bus.mem_wr) begin
                    strobes++;
                    last_rd    = bus.mem_rd;
                    addr_seen  = bus.mem_addr;
                    wdata_seen = bus.mem_wdata;
                end
                bus.mem_ready = (v.ready_delay == strobes - 1);
            end
        end
        bus.mem_ready = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.dma_req   = 1'b0;

        exp_pulses = v.exp_dma ? (v.exp_err ? 4'b0001 : 4'b0010)
                               : (v.exp_err ? 4'b0100 : 4'b1000);
        check_output($sformatf("v%0d_latency", idx), 32'(cycles), 32'(v.exp_cycles));
        check_output($sformatf("v%0d_pulse_owner", idx), 32'(pulses), 32'(exp_pulses));
        check_output($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'(v.exp_strobes));
        check_output($sformatf("v%0d_strobe_kind", idx), 32'(last_rd), 32'(!v.exp_wr));
        check_output($sformatf("v%0d_mem_addr", idx), addr_seen, v.exp_addr);
        check_output($sformatf("v%0d_mem_wdata", idx), wdata_seen, v.exp_wdata);
        check_output($sformatf("v%0d_both_strobes", idx), 32'(both), 32'd0);
        check_output($sformatf("v%0d_resp_strobes", idx), 32'(resp_strobes), 32'd0);
        check_output($sformatf("v%0d_rdata", idx), rdata_seen, v.exp_rdata);

        @(posedge clk);
        @(negedge clk);
        check_output($sformatf("v%0d_idle_after", idx),
                     32'({bus.busy, bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err}), 32'd0);
    endtask

    initial begin
        int          quiet;
        int          pulses;
        int          grants;
        int          both;
        int          alt_err;
        int          gap_err;
        int          err_pulses;
        int          dbl_pulses;
        int          last_cycle;
        int          cyc;
        logic        prev_strobe;
        logic        prev_owner;
        logic        first_owner;
        logic        third_owner;

        check_cnt = 0;
        pass_cnt  = 0;

        //           creq  dreq  cwr   dwr   caddr         daddr         cwdata        dwdata        dly mrdata       | dma  err   wr    addr          wdata         stb cyc rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0,         0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        1,  2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0040, 32'h0,        32'h1234_5678, 5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 6,  7, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 1,  2, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0300, 32'h0,        32'h0,         2, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0,        3,  4, 32'hA5A5_0001};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        32'h0,        -1, 32'h7777_7777, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0,        16, 17, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0500, 32'h0,        32'h0,         1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0,        2,  3, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h0000_0600, 32'h0,        32'hCAFE_0006, -1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'hCAFE_0006, 16, 17, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0800, 32'hC0DE_0007, 32'h0,        15, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'hC0DE_0007, 16, 17, 32'h0BAD_F00D};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'h0000_0A00, 32'h0,        32'h0,         0, 32'h600D_D00D, 1'b1, 1'b0, 1'b0, 32'h0000_0A00, 32'h0,        1,  2, 32'h600D_D00D};

        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.dma_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.dma_wr    = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.dma_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.dma_wdata = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_output("reset_ctrl",
                     32'({bus.cpu_done, bus.cpu_err, bus.dma_done, bus.dma_err,
                          bus.mem_rd, bus.mem_wr, bus.busy}), 32'd0);
        check_output("reset_rdata", bus.rdata, 32'd0);
        check_output("reset_mem_addr", bus.mem_addr, 32'd0);
        check_output("reset_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Reset during the third ACCESS cycle of a CPU read
        $display("[TB] reset during access");
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 32'h0000_0B00;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check_output("pre_reset_strobe", 32'({bus.mem_rd, bus.mem_wr, bus.busy}), 32'b101);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_ctrl", 32'({bus.mem_rd, bus.mem_wr, bus.busy}), 32'd0);
        check_output("async_reset_rdata", bus.rdata, 32'd0);
        check_output("async_reset_addr", bus.mem_addr, 32'd0);
        bus.cpu_req = 1'b0;
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_done || bus.cpu_err || bus.dma_done || bus.dma_err) quiet++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.cpu_done || bus.cpu_err || bus.dma_done || bus.dma_err) quiet++;
        check_output("no_pulse_after_reset", 32'(quiet), 32'd0);
        apply_stimulus(vecs[0], 100);

        // Back-to-back competing writes straight out of reset
        $display("[TB] continuous competition");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.dma_req   = 1'b1;
        bus.cpu_wr    = 1'b1;
        bus.dma_wr    = 1'b1;
        bus.cpu_addr  = 32'h0000_1000;
        bus.dma_addr  = 32'h0000_2000;
        bus.mem_ready = 1'b1;
        pulses      = 0;
        grants      = 0;
        both        = 0;
        alt_err     = 0;
        gap_err     = 0;
        err_pulses  = 0;
        dbl_pulses  = 0;
        last_cycle  = 0;
        cyc         = 0;
        prev_strobe = 1'b0;
        prev_owner  = 1'b0;
        first_owner = 1'b1;
        third_owner = 1'b1;
        while (pulses < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_rd && bus.mem_wr) both++;
            if ((bus.mem_rd || bus.mem_wr) && !prev_strobe) grants++;
            prev_strobe = bus.mem_rd || bus.mem_wr;
            if (bus.cpu_err || bus.dma_err) err_pulses++;
            if (bus.cpu_done && bus.dma_done) dbl_pulses++;
            if (bus.cpu_done || bus.dma_done) begin
                pulses++;
                if (pulses == 1) first_owner = bus.dma_done;
                if (pulses == 3) third_owner = bus.dma_done;
                if (pulses > 1) begin
                    if (bus.dma_done == prev_owner) alt_err++;
                    if (cyc - last_cycle != 3) gap_err++;
                end
                prev_owner = bus.dma_done;
                last_cycle = cyc;
            end
        end
        bus.cpu_req   = 1'b0;
        bus.dma_req   = 1'b0;
        bus.mem_ready = 1'b0;
        check_output("cont_pulses", 32'(pulses), 32'd20);
        check_output("cont_grants", 32'(grants), 32'd20);
        check_output("cont_first_cpu", 32'(first_owner), 32'd0);
        check_output("cont_third_cpu", 32'(third_owner), 32'd0);
        check_output("cont_alternation", 32'(alt_err), 32'd0);
        check_output("cont_regrant_gap", 32'(gap_err), 32'd0);
        check_output("cont_both_strobes", 32'(both), 32'd0);
        check_output("cont_err_pulses", 32'(err_pulses), 32'd0);
        check_output("cont_double_pulse", 32'(dbl_pulses), 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
